// File: rtl/commit_unit_nw.sv
// N-wide in-order commit stage: retires the longest legal prefix of ready ROB-head
// entries, sequences stores through a req/ack handshake and raises a registered
// flush pulse with a programmable drain window on a taken branch.
module commit_unit_nw #(
  parameter int unsigned NSIZE          = 2,
  parameter int unsigned ROB_DEPTH_BITS = 5,
  parameter int unsigned PR_BITS        = 6,
  parameter int unsigned FLUSH_DRAIN    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ROB_DEPTH_BITS:0]     rob_count,
  input  logic [NSIZE-1:0]            head_ready,
  input  logic [NSIZE-1:0]            head_is_store,
  input  logic [NSIZE-1:0]            head_is_branch,
  input  logic [NSIZE*5-1:0]          head_rd,
  input  logic [NSIZE*PR_BITS-1:0]    head_pd,
  input  logic [NSIZE*PR_BITS-1:0]    rrf_pd_old,
  input  logic [NSIZE-1:0]            bq_taken,
  input  logic [NSIZE*32-1:0]         bq_target,
  output logic [NSIZE-1:0]            rob_dequeue,
  output logic [NSIZE-1:0]            rrf_we,
  output logic [NSIZE*5-1:0]          rrf_rd,
  output logic [NSIZE*PR_BITS-1:0]    rrf_pd,
  output logic [NSIZE-1:0]            fl_enqueue,
  output logic [NSIZE*PR_BITS-1:0]    fl_din,
  output logic [NSIZE-1:0]            bq_dequeue,
  output logic                        st_req,
  input  logic                        st_ack,
  output logic                        flush,
  output logic [31:0]                 flush_pc,
  output logic [63:0]                 retire_count,
  output logic                        busy
);

  localparam int unsigned CntW = ROB_DEPTH_BITS + 1;

  typedef enum logic [1:0] {StRun, StStoreWait, StFlush} state_e;

  state_e      state_q, state_d;
  logic        st_req_q, st_req_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic [63:0] retire_count_q, retire_count_d;
  logic [3:0]  drain_q, drain_d;

  // Retirement selection, packing of frees/branch pops, and next-state logic.
  always_comb begin
    int unsigned k;
    int unsigned b;
    logic        go;
    logic        taken;
    logic [31:0] tgt;
    logic [63:0] n_ret;

    rob_dequeue    = '0;
    rrf_we         = '0;
    rrf_rd         = '0;
    rrf_pd         = '0;
    fl_enqueue     = '0;
    fl_din         = '0;
    bq_dequeue     = '0;
    busy           = 1'b0;
    state_d        = state_q;
    st_req_d       = st_req_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;
    drain_d        = drain_q;
    k              = 0;
    b              = 0;
    go             = 1'b1;
    taken          = 1'b0;
    tgt            = '0;
    n_ret          = '0;

    if (rst_n) begin
      busy = (state_q != StRun);
      unique case (state_q)
        StRun: begin
          for (int i = 0; i < int'(NSIZE); i++) begin
            if (go && (rob_count > CntW'(i)) && head_ready[i] && !head_is_store[i]) begin
              rob_dequeue[i]           = 1'b1;
              rrf_we[i]                = 1'b1;
              rrf_rd[i*5 +: 5]         = head_rd[i*5 +: 5];
              rrf_pd[i*PR_BITS +: PR_BITS] = head_pd[i*PR_BITS +: PR_BITS];
              // The displaced mapping is freed only if it really changes and rd is not x0.
              if ((rrf_pd_old[i*PR_BITS +: PR_BITS] != head_pd[i*PR_BITS +: PR_BITS]) &&
                  (head_rd[i*5 +: 5] != 5'd0)) begin
                fl_enqueue[k]                = 1'b1;
                fl_din[k*PR_BITS +: PR_BITS] = rrf_pd_old[i*PR_BITS +: PR_BITS];
                k++;
              end
              // Branch-queue entries are indexed by branch ordinal, not slot.
              if (head_is_branch[i]) begin
                bq_dequeue[b] = 1'b1;
                if (bq_taken[b]) begin
                  taken = 1'b1;
                  tgt   = bq_target[b*32 +: 32];
                  go    = 1'b0;
                end
                b++;
              end
            end else begin
              go = 1'b0;
            end
          end
          if (taken) begin
            flush_d    = 1'b1;
            flush_pc_d = tgt;
            drain_d    = 4'(FLUSH_DRAIN);
            state_d    = StFlush;
          end else if ((rob_count != '0) && head_ready[0] && head_is_store[0]) begin
            st_req_d = 1'b1;
            state_d  = StStoreWait;
          end
        end
        StStoreWait: begin
          if (st_ack) begin
            rob_dequeue[0] = 1'b1;
            st_req_d       = 1'b0;
            state_d        = StRun;
          end
        end
        StFlush: begin
          if (drain_q == 4'd0) begin
            state_d = StRun;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end

    for (int i = 0; i < int'(NSIZE); i++) begin
      n_ret = n_ret + 64'(rob_dequeue[i]);
    end
    retire_count_d = retire_count_q + n_ret;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      st_req_q       <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
      retire_count_q <= '0;
      drain_q        <= '0;
    end else begin
      state_q        <= state_d;
      st_req_q       <= st_req_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
      retire_count_q <= retire_count_d;
      drain_q        <= drain_d;
    end
  end

  assign st_req       = st_req_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign retire_count = retire_count_q;

endmodule

// File: doc/commit_unit_nw.md
Name: commit_unit_nw

Overview:
N-wide in-order retirement stage that sits between the ROB head and the RRF, free list and branch queue. Each cycle it retires the longest legal prefix of ready ROB-head entries. It sequences store commits through a request/acknowledge handshake with the store buffer. On a taken branch it raises a registered pipeline flush with a programmable drain window. It also keeps a retired-instruction counter.

Parameters:
NSIZE, 2, commit width (slots examined per cycle); power of two, 1..8
ROB_DEPTH_BITS, 5, ROB index width; occupancy is ROB_DEPTH_BITS+1 bits
PR_BITS, 6, physical register index width
FLUSH_DRAIN, 2, idle cycles after the flush pulse before commit resumes; 0..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rob_count  in  ROB_DEPTH_BITS+1  ROB occupancy
head_ready  in  NSIZE  slot i result ready
head_is_store  in  NSIZE  slot i is a store
head_is_branch  in  NSIZE  slot i is jal/jalr/br
head_rd  in  NSIZE*5  architectural destination per slot
head_pd  in  NSIZE*PR_BITS  physical destination per slot
rrf_pd_old  in  NSIZE*PR_BITS  current RRF mapping of head_rd[i]
bq_taken  in  NSIZE  mispredict/taken flag, indexed by branch ordinal within the group
bq_target  in  NSIZE*32  redirect PC, indexed by branch ordinal within the group
rob_dequeue  out  NSIZE  retire slot i (thermometer, low-aligned)
rrf_we  out  NSIZE  RRF write enable per slot
rrf_rd  out  NSIZE*5  RRF write address
rrf_pd  out  NSIZE*PR_BITS  RRF write data
fl_enqueue  out  NSIZE  free-list push enables, packed from bit 0
fl_din  out  NSIZE*PR_BITS  freed physical registers, packed
bq_dequeue  out  NSIZE  branch-queue pops, packed from bit 0
st_req  out  1  store commit request, registered
st_ack  in  1  store buffer has performed the head store
flush  out  1  pipeline flush, one-cycle registered pulse
flush_pc  out  32  redirect target, valid with flush
retire_count  out  64  total retired instructions, registered
busy  out  1  high in STORE_WAIT or FLUSH

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, st_req=0, flush=0, flush_pc=0, retire_count=0, drain counter=0. All combinational outputs are 0 while rst_n is low.
- States: RUN, STORE_WAIT, FLUSH.
- Eligibility in RUN: slot i is eligible iff rob_count > i, head_ready[i]=1, all slots j<i retire this cycle, and head_is_store[i]=0. The first ineligible slot ends the group.
- Each retiring slot i drives rob_dequeue[i]=1, rrf_we[i]=1, rrf_rd=head_rd[i], rrf_pd=head_pd[i]. These outputs are combinational in the same cycle as the inputs.
- Freeing: if rrf_pd_old[i] != head_pd[i] and head_rd[i] != 0, push rrf_pd_old[i] into the next packed fl slot (k-th freed register in fl_din[k]).
- Branches: the k-th retiring branch pops bq_dequeue[k] and examines bq_taken[k]. If taken, that slot retires and is the last slot in the group. Next edge: flush=1, flush_pc=bq_target[k], state->FLUSH, drain counter loaded with FLUSH_DRAIN.
- FLUSH: flush returns to 0 after one cycle; no slot retires. Drain counter decrements each cycle; when it reaches 0, state->RUN. With FLUSH_DRAIN=0, RUN resumes the cycle after the pulse.
- Store at slot 0 in RUN: if rob_count>0 and head_ready[0] and head_is_store[0], nothing retires this cycle. Next edge: st_req=1, state->STORE_WAIT.
- Store at slot i>0: the group ends before it; the store becomes slot 0 on a later cycle.
- STORE_WAIT: st_req held at 1. When st_ack=1, slot 0 retires the same cycle (rob_dequeue[0]=1, no RRF write, no free). Next edge: st_req=0, state->RUN. st_ack while not in STORE_WAIT is ignored.
- retire_count += popcount(rob_dequeue) every cycle; 64-bit wrap.
- If rob_count drops to 0 in RUN, nothing retires; this is not an error.

Test Plan:
- NSIZE=2, rob_count=3, ready=11, no store/branch, rd={5,6}, pd={20,21}, old={9,21} -> rob_dequeue=11, fl_enqueue=01, fl_din[0]=9, retire_count +2.
- ready=10 -> rob_dequeue=00: slot 1 is blocked by slot 0 not ready.
- Slot 0 store ready -> no retire; st_req=1 next cycle. st_ack asserted 3 cycles later -> rob_dequeue=01 that cycle, st_req=0 next cycle, retire_count +1.
- Slot 0 taken branch, bq_target=0x1000_0040, slot 1 ready -> rob_dequeue=01, bq_dequeue=01. Next cycle flush=1, flush_pc=0x10000040, then 2 cycles with no retire, then RUN.
- rst_n pulsed low mid-STORE_WAIT -> st_req=0 immediately, state RUN, retire_count=0.
- rd=0 with pd_old != pd -> rrf_we=1, fl_enqueue=0.
